// File: rtl/pipeexe_mdu_if.sv
// D/E -> E -> E/M bundle for the pipeexe_mdu execute stage.
// master: the pipeline control side (drives D/E fields, reads E results).
// slave:  the execute stage itself.
interface pipeexe_mdu_if;
  logic [31:0] ea;
  logic [31:0] eb;
  logic [31:0] eimm;
  logic [31:0] epc4;
  logic [4:0]  ern0;
  logic [3:0]  ealuc;
  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic        ealuimm;
  logic        eshift;
  logic        ejal;
  logic [3:0]  emdop;
  logic [31:0] ealu;
  logic [4:0]  ern;
  logic        ewreg_o;
  logic        em2reg_o;
  logic        ewmem_o;
  logic [31:0] eb_o;
  logic        estall;
  logic        emd_busy;

  modport master (
    output ea, eb, eimm, epc4, ern0, ealuc, ewreg, em2reg, ewmem,
           ealuimm, eshift, ejal, emdop,
    input  ealu, ern, ewreg_o, em2reg_o, ewmem_o, eb_o, estall, emd_busy
  );

  modport slave (
    input  ea, eb, eimm, epc4, ern0, ealuc, ewreg, em2reg, ewmem,
           ealuimm, eshift, ejal, emdop,
    output ealu, ern, ewreg_o, em2reg_o, ewmem_o, eb_o, estall, emd_busy
  );
endinterface

// File: rtl/pipeexe_mdu.sv
// Execute stage: ALU, result/destination select, and an iterative
// multiply/divide unit with HI/LO. Optional macro EXE_DIV_EN compiles in
// DIV/DIVU; without it emdop 3/4 behave as no MDU operation.
module pipeexe_mdu #(
  parameter logic [4:0]  RA_REG  = 5'd31,
  parameter logic [31:0] DIVZ_LO = 32'hFFFFFFFF
) (
  input logic          clock,
  input logic          reset,
  pipeexe_mdu_if.slave e
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t      state_q;
  logic        busy_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] md_q;          // multiplicand or divisor magnitude
  logic [63:0] p_q, p_d;      // MUL: product/multiplier; DIV: remainder/quotient
  logic        neg_q;         // negate product / quotient at completion
  logic [63:0] prod_c;
`ifdef EXE_DIV_EN
  logic        rneg_q;
  logic        divz_q;
  logic [32:0] sh, diff;
`endif

  logic [31:0] alua, alub, alu_r;
  logic        op_mul, op_div, op_mdu, op_sgn, a_neg, b_neg;
  logic [31:0] abs_a, abs_b;

  assign alua = e.eshift ? {27'b0, e.eimm[10:6]} : e.ea;
  assign alub = e.ealuimm ? e.eimm : e.eb;

  // ALU function select
  always_comb begin
    alu_r = '0;
    casez (e.ealuc)
      4'b?000: alu_r = alua + alub;
      4'b?100: alu_r = alua - alub;
      4'b?001: alu_r = alua & alub;
      4'b?101: alu_r = alua | alub;
      4'b?010: alu_r = alua ^ alub;
      4'b?110: alu_r = alub << 16;
      4'b0011: alu_r = alub << alua[4:0];
      4'b0111: alu_r = alub >> alua[4:0];
      4'b1111: alu_r = $signed(alub) >>> alua[4:0];
      default: alu_r = '0;
    endcase
  end

  assign op_mul = (e.emdop == 4'd1) || (e.emdop == 4'd2);
`ifdef EXE_DIV_EN
  assign op_div = (e.emdop == 4'd3) || (e.emdop == 4'd4);
`else
  assign op_div = 1'b0;
`endif
  assign op_mdu = op_mul || op_div || ((e.emdop >= 4'd5) && (e.emdop <= 4'd8));
  assign op_sgn = (e.emdop == 4'd1) || (e.emdop == 4'd3);
  assign a_neg  = op_sgn & e.ea[31];
  assign b_neg  = op_sgn & e.eb[31];
  assign abs_a  = a_neg ? -e.ea : e.ea;
  assign abs_b  = b_neg ? -e.eb : e.eb;

  assign e.estall   = busy_q & op_mdu;
  assign e.emd_busy = busy_q;
  assign e.ewreg_o  = e.ewreg & ~e.estall;
  assign e.ewmem_o  = e.ewmem & ~e.estall;
  assign e.em2reg_o = e.em2reg & ~e.estall;
  assign e.eb_o     = e.eb;
  assign e.ern      = e.ejal ? RA_REG : e.ern0;
  assign e.ealu     = e.ejal                ? e.epc4 + 32'd4 :
                      (e.emdop == 4'd5)     ? hi_q :
                      (e.emdop == 4'd6)     ? lo_q : alu_r;

  // One shift-add or restoring-divide step per cycle
  always_comb begin
    p_d = p_q;
`ifdef EXE_DIV_EN
    sh   = '0;
    diff = '0;
`endif
    if (state_q == S_MUL) begin
      p_d = {({1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, md_q} : 33'd0)), p_q[31:1]};
    end
`ifdef EXE_DIV_EN
    else if (state_q == S_DIV) begin
      sh   = {p_q[63:32], p_q[31]};
      diff = sh - {1'b0, md_q};
      p_d  = diff[32] ? {sh[31:0], p_q[30:0], 1'b0} : {diff[31:0], p_q[30:0], 1'b1};
    end
`endif
  end

  assign prod_c = neg_q ? -p_d : p_d;

  // MDU sequencer, HI/LO and move-to writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      md_q    <= '0;
      p_q     <= '0;
      neg_q   <= 1'b0;
`ifdef EXE_DIV_EN
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!e.estall) begin
            if (op_mul) begin
              state_q <= S_MUL;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              md_q    <= abs_a;
              p_q     <= {32'b0, abs_b};
              neg_q   <= a_neg ^ b_neg;
            end
`ifdef EXE_DIV_EN
            else if (op_div) begin
              state_q <= S_DIV;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              md_q    <= abs_b;
              p_q     <= {32'b0, abs_a};
              neg_q   <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              divz_q  <= (e.eb == '0);
            end
`endif
            else if (e.emdop == 4'd7) hi_q <= e.ea;
            else if (e.emdop == 4'd8) lo_q <= e.ea;
          end
        end
        S_MUL: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            {hi_q, lo_q} <= prod_c;
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
          end
        end
`ifdef EXE_DIV_EN
        S_DIV: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            // with a zero divisor the remainder ends as |ea|; re-signing it yields ea
            hi_q    <= rneg_q ? -p_d[63:32] : p_d[63:32];
            lo_q    <= divz_q ? DIVZ_LO : (neg_q ? -p_d[31:0] : p_d[31:0]);
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeexe_mdu.sv
// Scoreboard bench for pipeexe_mdu: stimulus pushes the expected E-stage
// outputs for each cycle; a negedge monitor pops and compares them.
module tb_pipeexe_mdu;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipeexe_mdu_if bus ();

  pipeexe_mdu #(.RA_REG(5'd31), .DIVZ_LO(32'hFFFFFFFF)) dut (
    .clock (clock),
    .reset (reset),
    .e     (bus.slave)
  );

  typedef struct {
    string       nm;
    logic [31:0] alu;
    logic        chk;
    logic [4:0]  rn;
    logic        wr;
    logic        st;
    logic        bz;
    logic [31:0] b;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", nm, f, act, exp);
    end
  endtask

  // monitor: compare every presented E-stage output against the scoreboard
  always @(negedge clock) begin
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      if (x.chk) cmp(x.nm, "ealu", bus.ealu, x.alu);
      cmp(x.nm, "ern",      {27'b0, bus.ern},      {27'b0, x.rn});
      cmp(x.nm, "ewreg_o",  {31'b0, bus.ewreg_o},  {31'b0, x.wr});
      cmp(x.nm, "ewmem_o",  {31'b0, bus.ewmem_o},  {31'b0, x.wr});
      cmp(x.nm, "em2reg_o", {31'b0, bus.em2reg_o}, {31'b0, x.wr});
      cmp(x.nm, "estall",   {31'b0, bus.estall},   {31'b0, x.st});
      cmp(x.nm, "emd_busy", {31'b0, bus.emd_busy}, {31'b0, x.bz});
      cmp(x.nm, "eb_o",     bus.eb_o,              x.b);
    end
  end

  // drive one E-stage cycle and record what it must produce
  task automatic op(input string nm, input logic [3:0] md, input logic [31:0] a, input logic [31:0] b,
                    input logic [3:0] aluc, input logic wr, input logic [4:0] rn,
                    input logic [31:0] x_alu, input logic x_chk, input logic [4:0] x_rn,
                    input logic x_wr, input logic x_st, input logic x_bz);
    exp_t x;
    bus.emdop  = md;
    bus.ea     = a;
    bus.eb     = b;
    bus.ealuc  = aluc;
    bus.ewreg  = wr;
    bus.ewmem  = wr;
    bus.em2reg = wr;
    bus.ern0   = rn;
    x.nm = nm; x.alu = x_alu; x.chk = x_chk; x.rn = x_rn;
    x.wr = x_wr; x.st = x_st; x.bz = x_bz; x.b = b;
    sbq.push_back(x);
    @(posedge clock);
    #1;
  endtask

  // MDU instruction waiting in E while the unit is busy
  task automatic stalled(input string nm, input int unsigned n, input logic [3:0] md,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rn);
    for (int unsigned i = 0; i < n; i++)
      op(nm, md, a, b, 4'b0000, 1'b1, rn, 32'h0, 1'b0, rn, 1'b0, 1'b1, 1'b1);
  endtask

  // non-MDU bubbles while the unit is busy
  task automatic nops(input string nm, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      op(nm, 4'd0, 32'h0, 32'h0, 4'b0000, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.ea = '0; bus.eb = '0; bus.eimm = '0; bus.epc4 = '0; bus.ern0 = '0;
    bus.ealuc = '0; bus.ewreg = 1'b0; bus.em2reg = 1'b0; bus.ewmem = 1'b0;
    bus.ealuimm = 1'b0; bus.eshift = 1'b0; bus.ejal = 1'b0; bus.emdop = '0;
    @(posedge clock);
    #1;

    op("rst_hi", 4'd5, 0, 0, 4'b0000, 1, 5'd3, 32'h0, 1, 5'd3, 1, 0, 0);
    reset = 1'b0;
    op("rst_lo", 4'd6, 0, 0, 4'b0000, 1, 5'd3, 32'h0, 1, 5'd3, 1, 0, 0);

    op("add", 4'd0, 32'd5, 32'd7, 4'b0000, 1, 5'd4, 32'd12, 1, 5'd4, 1, 0, 0);
    op("sub", 4'd0, 32'd5, 32'd7, 4'b0100, 1, 5'd4, 32'hFFFFFFFE, 1, 5'd4, 1, 0, 0);
    op("or",  4'd0, 32'hF0, 32'h0F, 4'b0101, 1, 5'd5, 32'hFF, 1, 5'd5, 1, 0, 0);
    op("xor", 4'd0, 32'hFF, 32'h0F, 4'b0010, 1, 5'd5, 32'hF0, 1, 5'd5, 1, 0, 0);
    op("lui", 4'd0, 32'h0, 32'h1234, 4'b0110, 1, 5'd6, 32'h12340000, 1, 5'd6, 1, 0, 0);
    op("bad_aluc", 4'd0, 32'h5, 32'h7, 4'b1011, 1, 5'd6, 32'h0, 1, 5'd6, 1, 0, 0);
    bus.eshift = 1'b1; bus.eimm = 32'h100;
    op("sra", 4'd0, 32'h0, 32'h80000000, 4'b1111, 1, 5'd7, 32'hF8000000, 1, 5'd7, 1, 0, 0);
    op("srl", 4'd0, 32'h0, 32'h80000000, 4'b0111, 1, 5'd7, 32'h08000000, 1, 5'd7, 1, 0, 0);
    op("sll", 4'd0, 32'h0, 32'h1, 4'b0011, 1, 5'd7, 32'h10, 1, 5'd7, 1, 0, 0);
    bus.eshift = 1'b0; bus.ealuimm = 1'b1; bus.eimm = 32'hFFFFFFFF;
    op("addi", 4'd0, 32'h1, 32'h55, 4'b0000, 1, 5'd8, 32'h0, 1, 5'd8, 1, 0, 0);
    bus.ealuimm = 1'b0; bus.eimm = 32'h0;
    bus.ejal = 1'b1; bus.epc4 = 32'h100;
    op("jal", 4'd0, 32'h0, 32'h0, 4'b0000, 1, 5'd0, 32'h104, 1, 5'd31, 1, 0, 0);
    bus.ejal = 1'b0; bus.epc4 = 32'h0;

    op("mthi", 4'd7, 32'hDEADBEEF, 0, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    op("mtlo", 4'd8, 32'h0BADF00D, 0, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    op("mfhi_mt", 4'd5, 0, 0, 4'b0000, 1, 5'd9, 32'hDEADBEEF, 1, 5'd9, 1, 0, 0);
    op("mflo_mt", 4'd6, 0, 0, 4'b0000, 1, 5'd9, 32'h0BADF00D, 1, 5'd9, 1, 0, 0);

    // MULT -3 * 7, MFLO waits in E for exactly 32 cycles
    op("mult", 4'd1, 32'hFFFFFFFD, 32'd7, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    stalled("mult_stall", 32, 4'd6, 0, 0, 5'd2);
    op("mult_lo", 4'd6, 0, 0, 4'b0000, 1, 5'd2, 32'hFFFFFFEB, 1, 5'd2, 1, 0, 0);
    op("mult_hi", 4'd5, 0, 0, 4'b0000, 1, 5'd2, 32'hFFFFFFFF, 1, 5'd2, 1, 0, 0);

    // MULTU 0xFFFFFFFF * 2
    op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    stalled("multu_stall", 32, 4'd5, 0, 0, 5'd3);
    op("multu_hi", 4'd5, 0, 0, 4'b0000, 1, 5'd3, 32'h1, 1, 5'd3, 1, 0, 0);
    op("multu_lo", 4'd6, 0, 0, 4'b0000, 1, 5'd3, 32'hFFFFFFFE, 1, 5'd3, 1, 0, 0);

    // back-to-back MULT: second one held through the completing cycle, then starts
    op("mult_a", 4'd1, 32'd3, 32'd5, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    stalled("mult_b_stall", 32, 4'd1, 32'hFFFFFFFE, 32'hFFFFFFFC, 5'd0);
    op("mult_b", 4'd1, 32'hFFFFFFFE, 32'hFFFFFFFC, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    op("add_busy", 4'd0, 32'd1, 32'd2, 4'b0000, 1, 5'd10, 32'd3, 1, 5'd10, 1, 0, 1);
    nops("mult_b_busy", 31);
    op("mult_b_lo", 4'd6, 0, 0, 4'b0000, 1, 5'd4, 32'd8, 1, 5'd4, 1, 0, 0);
    op("mult_b_hi", 4'd5, 0, 0, 4'b0000, 1, 5'd4, 32'd0, 1, 5'd4, 1, 0, 0);

`ifdef EXE_DIV_EN
    op("divu", 4'd4, 32'd100, 32'd7, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    stalled("divu_stall", 32, 4'd6, 0, 0, 5'd5);
    op("divu_lo", 4'd6, 0, 0, 4'b0000, 1, 5'd5, 32'd14, 1, 5'd5, 1, 0, 0);
    op("divu_hi", 4'd5, 0, 0, 4'b0000, 1, 5'd5, 32'd2, 1, 5'd5, 1, 0, 0);
    op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    stalled("div_stall", 32, 4'd6, 0, 0, 5'd5);
    op("div_lo", 4'd6, 0, 0, 4'b0000, 1, 5'd5, 32'hFFFFFFFD, 1, 5'd5, 1, 0, 0);
    op("div_hi", 4'd5, 0, 0, 4'b0000, 1, 5'd5, 32'hFFFFFFFF, 1, 5'd5, 1, 0, 0);
    op("divz", 4'd3, 32'h1234, 32'd0, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    op("divz_add", 4'd0, 32'd1, 32'd2, 4'b0000, 1, 5'd11, 32'd3, 1, 5'd11, 1, 0, 1);
    nops("divz_busy", 31);
    op("divz_hi", 4'd5, 0, 0, 4'b0000, 1, 5'd6, 32'h1234, 1, 5'd6, 1, 0, 0);
    op("divz_lo", 4'd6, 0, 0, 4'b0000, 1, 5'd6, 32'hFFFFFFFF, 1, 5'd6, 1, 0, 0);
`else
    op("mthi2", 4'd7, 32'h11111111, 0, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    op("mtlo2", 4'd8, 32'h22222222, 0, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    op("div_none", 4'd3, 32'd5, 32'd1, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    op("div_none_hi", 4'd5, 0, 0, 4'b0000, 1, 5'd6, 32'h11111111, 1, 5'd6, 1, 0, 0);
    op("divu_none", 4'd4, 32'd5, 32'd0, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    op("divu_none_lo", 4'd6, 0, 0, 4'b0000, 1, 5'd6, 32'h22222222, 1, 5'd6, 1, 0, 0);
`endif

    // reset in the middle of a MULT
    op("mult_r", 4'd1, 32'd5, 32'd5, 4'b0000, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0);
    nops("mult_r_busy", 9);
    reset = 1'b1;
    op("rst_mid", 4'd5, 0, 0, 4'b0000, 1, 5'd7, 32'h0, 1, 5'd7, 1, 0, 0);
    reset = 1'b0;
    op("rst_mfhi", 4'd5, 0, 0, 4'b0000, 1, 5'd7, 32'h0, 1, 5'd7, 1, 0, 0);
    op("rst_mflo", 4'd6, 0, 0, 4'b0000, 1, 5'd7, 32'h0, 1, 5'd7, 1, 0, 0);
    nops("rst_idle", 0);
    op("rst_nop", 4'd0, 0, 0, 4'b0000, 0, 5'd0, 32'h0, 1, 5'd0, 0, 0, 0);

    repeat (3) @(negedge clock);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
